// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate response checker: FSM states,
// vector count and the truth tables of the common two-input gates.
package gate_chk_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  localparam int unsigned NUM_VECTORS = 4;

  // Bit i of a table is the gate output for input vector i = {a,b}.
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_XOR = 4'b0110;

  function automatic logic [3:0] vec_onehot(input logic [1:0] vec);
    vec_onehot = 4'b0001 << vec;
  endfunction

endpackage

// File: rtl/gate_chk_hold_timer.sv
// Down-counter that times how long each stimulus vector is held; a load
// has priority over a decrement, and the count saturates at zero.
module gate_chk_hold_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state is written with <= only, so every flop samples
  // the pre-edge value of its neighbours regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/gate_response_checker.sv
// Drives the four {d1,d2} vectors into a two-input gate, holds each for
// HOLD_CYCLES clocks, compares the gate output with TRUTH and reports.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 5,
  parameter logic [3:0]  TRUTH       = TT_AND
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       d1,
  output logic       d2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

  state_t     r_state;
  logic [1:0] r_vec;
  logic       r_d1, r_d2, r_busy, r_done, r_pass;
  logic [2:0] r_err_count;
  logic [3:0] r_fail_vec;

  logic       w_load, w_dec, w_zero, w_mismatch, w_last;
  logic [2:0] w_err_next;
  logic [3:0] w_fail_next;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_mismatch  = (dut_out != TRUTH[r_vec]);
    w_last      = (r_vec == LAST_VEC);
    w_err_next  = r_err_count + {2'b00, w_mismatch};
    w_fail_next = r_fail_vec | (w_mismatch ? vec_onehot(r_vec) : 4'b0000);
    w_load      = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE:  w_load = start && !abort;
      ST_APPLY: begin
        if (!abort) begin
          w_load = w_zero && !w_last;
          w_dec  = !w_zero;
        end
      end
      default: ;
    endcase
  end

  gate_chk_hold_timer #(
    .WIDTH (8)
  ) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (HOLD_RELOAD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_vec       <= 2'b00;
      r_d1        <= 1'b0;
      r_d2        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 3'd0;
      r_fail_vec  <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // An abort here only withdraws the previous verdict.
          if (abort) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
          end else if (start) begin
            r_state     <= ST_APPLY;
            r_vec       <= 2'b00;
            r_d1        <= 1'b0;
            r_d2        <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_fail_vec  <= 4'b0000;
          end
        end
        ST_APPLY: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_vec   <= 2'b00;
            r_d1    <= 1'b0;
            r_d2    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (w_zero) begin
            r_err_count <= w_err_next;
            r_fail_vec  <= w_fail_next;
            if (w_last) begin
              r_state <= ST_IDLE;
              r_vec   <= 2'b00;
              r_d1    <= 1'b0;
              r_d2    <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == 3'd0);
            end else begin
              r_vec <= r_vec + 2'd1;
              {r_d1, r_d2} <= r_vec + 2'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign d1        = r_d1;
  assign d2        = r_d2;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench: two checkers (HOLD=5/AND and HOLD=1/XOR) driving
// modelled gates, compared every cycle with a run-level reference model.
module tb_gate_response_checker;
  import gate_chk_pkg::*;

  logic clk, rst_n;
  logic start0, abort0, start1, abort1;
  logic d1_0, d2_0, busy0, done0, pass0;
  logic d1_1, d2_1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] fail0, fail1;
  logic dut_out0, dut_out1;

  int mode[2];
  int n_checks = 0;
  int n_fail   = 0;

  // Gate behaviours: 0 AND, 1 OR, 2 XOR, 3 stuck-0, 4 stuck-1, 5 NAND.
  function automatic bit gate_fn(input int m, input bit a, input bit b);
    case (m)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return 1'b0;
      4: return 1'b1;
      default: return ~(a & b);
    endcase
  endfunction

  assign dut_out0 = gate_fn(mode[0], d1_0, d2_0);
  assign dut_out1 = gate_fn(mode[1], d1_1, d2_1);

  gate_response_checker #(.HOLD_CYCLES(5), .TRUTH(TT_AND)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .dut_out(dut_out0),
    .d1(d1_0), .d2(d2_0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fail0)
  );

  gate_response_checker #(.HOLD_CYCLES(1), .TRUTH(TT_XOR)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .dut_out(dut_out1),
    .d1(d1_1), .d2(d2_1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fail1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a run is "k edges since the accepted start"; vector
  // k/H is on the pins, and vector k/H-1 is judged whenever k is a multiple of H.
  int       m_h[2]  = '{5, 1};
  bit [3:0] m_tt[2] = '{4'b1000, 4'b0110};
  bit       m_run[2], m_done[2], m_pass[2];
  int       m_k[2], m_err[2];
  bit [3:0] m_fail[2];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_run[u] = 0; m_done[u] = 0; m_pass[u] = 0;
      m_k[u] = 0; m_err[u] = 0; m_fail[u] = '0;
    end
  endtask

  task automatic model_step(input int u, input bit st, input bit ab);
    int idx;
    if (!m_run[u]) begin
      if (ab) begin
        m_done[u] = 0; m_pass[u] = 0;
      end else if (st) begin
        m_run[u] = 1; m_k[u] = 0; m_done[u] = 0; m_pass[u] = 0;
        m_err[u] = 0; m_fail[u] = '0;
      end
    end else if (ab) begin
      m_run[u] = 0; m_done[u] = 0; m_pass[u] = 0;
    end else begin
      m_k[u]++;
      if (m_k[u] % m_h[u] == 0) begin
        idx = m_k[u] / m_h[u] - 1;
        if (gate_fn(mode[u], idx[1], idx[0]) != m_tt[u][idx]) begin
          m_err[u]++;
          m_fail[u][idx] = 1'b1;
        end
        if (idx == 3) begin
          m_run[u] = 0; m_done[u] = 1; m_pass[u] = (m_err[u] == 0);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      model_step(0, start0, abort0);
      model_step(1, start1, abort1);
    end
  end

  always @(negedge rst_n) model_reset();

  function automatic logic [11:0] exp_out(input int u);
    int dv;
    dv = m_run[u] ? (m_k[u] / m_h[u]) : 0;
    return {m_run[u], m_done[u], m_pass[u], 2'(dv), 3'(m_err[u]), m_fail[u]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: apply inputs, let the edge pass, compare both units at negedge.
  task automatic cycle(input bit s0, input bit a0, input bit s1, input bit a1);
    start0 = s0; abort0 = a0; start1 = s1; abort1 = a1;
    @(negedge clk);
    check("u0_outs", {busy0, done0, pass0, d1_0, d2_0, err0, fail0}, exp_out(0));
    check("u1_outs", {busy1, done1, pass1, d1_1, d2_1, err1, fail1}, exp_out(1));
  endtask

  task automatic run_u0(input int m);
    mode[0] = m;
    cycle(1, 0, 0, 0);
    repeat (20) cycle(0, 0, 0, 0);
  endtask

  initial begin
    mode[0] = 0; mode[1] = 2;
    start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
    model_reset();
    rst_n = 1'b0;
    #12;
    check("reset_u0", {busy0, done0, pass0, d1_0, d2_0, err0, fail0}, 12'h000);
    check("reset_u1", {busy1, done1, pass1, d1_1, d2_1, err1, fail1}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // abort beats start in IDLE; nothing runs afterwards
    cycle(1, 1, 1, 1);
    cycle(0, 0, 0, 0);
    check("abort_wins_idle", {busy0, busy1}, 2'b00);

    // correct AND (H=5) and XOR (H=1) started together at E0
    cycle(1, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0);
    check("h1_not_done_e3", done1, 1'b0);
    cycle(0, 0, 0, 0);
    check("h1_done_e4", {done1, pass1, err1, fail1}, {1'b1, 1'b1, 3'd0, 4'b0000});
    repeat (15) cycle(0, 0, 0, 0);
    check("and_busy_e19", {busy0, done0}, 2'b10);
    cycle(0, 0, 0, 0);
    check("and_done_e20", {busy0, done0, pass0, err0, fail0}, {1'b0, 1'b1, 1'b1, 3'd0, 4'b0000});

    // stuck-at-0 gate against AND
    run_u0(3);
    check("stuck0_result", {done0, pass0, err0, fail0}, {1'b1, 1'b0, 3'd1, 4'b1000});

    // start with done=1 clears the results immediately
    mode[0] = 0;
    cycle(1, 0, 0, 0);
    check("restart_clears", {busy0, done0, pass0, err0, fail0}, {1'b1, 1'b0, 1'b0, 3'd0, 4'b0000});
    repeat (20) cycle(0, 0, 0, 0);

    // OR gate against AND, with a start pulse during busy that must be ignored
    mode[0] = 1;
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (17) cycle(0, 0, 0, 0);
    check("or_result", {done0, pass0, err0, fail0}, {1'b1, 1'b0, 3'd2, 4'b0110});

    // abort taking effect at E0+7
    mode[0] = 0;
    cycle(1, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("abort_e7", {busy0, done0, d1_0, d2_0, fail0}, {1'b0, 1'b0, 2'b00, 4'b0000});
    run_u0(0);
    check("after_abort_clean", {done0, pass0, err0}, {1'b1, 1'b1, 3'd0});

    // asynchronous reset in the middle of a run
    mode[0] = 3;
    cycle(1, 0, 0, 0);
    repeat (11) cycle(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_u0", {busy0, done0, pass0, d1_0, d2_0, err0, fail0}, 12'h000);
    @(negedge clk);
    check("reset_hold_u0", {busy0, done0, pass0, d1_0, d2_0, err0, fail0}, exp_out(0));
    rst_n = 1'b1;
    repeat (3) cycle(0, 0, 0, 0);
    check("no_run_after_reset", busy0, 1'b0);

    // abort on the final compare edge of a failing run: done stays low
    mode[0] = 3;
    cycle(1, 0, 0, 0);
    repeat (19) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("abort_final_edge", {busy0, done0, pass0}, 3'b000);

    // randomized traffic checked every cycle against the model
    for (int i = 0; i < 600; i++) begin
      if (!m_run[0] && $urandom_range(3) == 0) mode[0] = $urandom_range(5);
      if (!m_run[1] && $urandom_range(3) == 0) mode[1] = $urandom_range(5);
      cycle($urandom_range(5) == 0, $urandom_range(29) == 0,
            $urandom_range(3) == 0, $urandom_range(19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 Parameter HOLD_CYCLES, default 5, number of clock cycles each input vector is held (legal range 1..255).
REQ-002 Parameter TRUTH, default 4'b1000, expected DUT output; bit i is the expected value for vector i = {d1,d2} (default = AND).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  begins one check run; sampled only in IDLE.
REQ-006 abort  input  1  cancels a run in progress.
REQ-007 dut_out  input  1  output of the gate under test.
REQ-008 d1  output  1  stimulus input A to the DUT; registered.
REQ-009 d2  output  1  stimulus input B to the DUT; registered.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high after a run completes; held until the next accepted start or abort.
REQ-012 pass  output  1  valid while done is high; 1 iff err_count == 0.
REQ-013 err_count  output  3  number of mismatching vectors in the last run (0..4).
REQ-014 fail_vec  output  4  bit i is set if vector i mismatched.

Function
REQ-015 FSM states SHALL be IDLE and APPLY only.
REQ-016 IDLE: busy=0; d1=d2=0; done, pass, err_count and fail_vec hold their last values.
REQ-017 Edge E0 with start=1, abort=0 in IDLE: state goes to APPLY, vec=0, hold_cnt=HOLD_CYCLES-1, busy=1, done=0, pass=0, err_count=0, fail_vec=0.
REQ-018 In APPLY, {d1,d2} SHALL equal vec at all times.
REQ-019 On an APPLY edge with hold_cnt != 0, hold_cnt decrements and nothing else changes.
REQ-020 On an APPLY edge with hold_cnt == 0, dut_out is compared to TRUTH[vec]; on mismatch, err_count increments and fail_vec[vec] is set.
REQ-021 After that compare, if vec < 3 then vec increments and hold_cnt reloads HOLD_CYCLES-1; if vec == 3 the state goes to IDLE with busy=0, done=1, pass=(final err_count==0), and d1=d2=0.
REQ-022 Vector k SHALL be sampled at edge E0+(k+1)*HOLD_CYCLES; done rises at edge E0+4*HOLD_CYCLES.
REQ-023 HOLD_CYCLES=1 SHALL sample every vector on the edge after it is applied, with no idle gap between vectors.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort in APPLY SHALL, on the next edge, go to IDLE with busy=0, done=0, pass=0, d1=d2=0; err_count and fail_vec keep their partial values.
REQ-026 abort and start both high in IDLE: abort wins and no run starts.
REQ-027 abort coinciding with the final compare edge: abort wins; done stays 0.
REQ-028 start in IDLE with done=1 SHALL start a fresh run and clear all result outputs per REQ-017.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, vec=0, hold_cnt=0, and d1, d2, busy, done, pass, err_count, fail_vec all to 0, including mid-run.
REQ-030 After rst_n deasserts, the first run SHALL require a new start.

Structure
REQ-031 Package gate_chk_pkg SHALL hold the state enum, the constant NUM_VECTORS=4, and truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110.
REQ-032 The hold counter SHALL be a sub-module, gate_chk_hold_timer, with load, decrement and zero-flag outputs.

Verification
REQ-033 Correct AND DUT, HOLD_CYCLES=5, start at E0 -> d1d2 = 00,01,10,11 for 5 cycles each; done=1 at E0+20; pass=1; err_count=0; fail_vec=0000.
REQ-034 DUT stuck-at-0, TRUTH=TT_AND -> err_count=1, fail_vec=1000, pass=0.
REQ-035 OR DUT, TRUTH=TT_AND -> err_count=2, fail_vec=0110, pass=0.
REQ-036 abort at E0+7 -> after the next edge busy=0, done=0, d1d2=00, fail_vec=0000; a later start runs cleanly.
REQ-037 rst_n low at E0+12 -> all outputs 0 asynchronously; start pulses during busy are ignored, and start with done=1 clears results.
REQ-038 HOLD_CYCLES=1, XOR DUT, TRUTH=TT_XOR -> done at E0+4, pass=1.
